interrupt_controller: RTL and testbench

Sequencing front end for the 68000 interrupt path. It synchronises the seven active-low request lines and holds edge-triggered requests in a pending register. It drives the registered, priority-encoded IPL to the CPU, then services the CPU interrupt-acknowledge cycle. That service returns a user vector, an autovector request, or a spurious-interrupt bus error. Sits between the board IRQ sources and the CPU core, next to the bus decoder that detects FC=7 IACK cycles.

---
 rtl/interrupt_pkg.sv | 19 +
 rtl/interrupt_encoder.sv | 17 +
 rtl/interrupt_controller.sv | 141 ++++++++++++++
 tb/tb_interrupt_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_pkg.sv
// Shared types and constants for the 68000 interrupt sequencing front end.
package interrupt_pkg;

  localparam int LEVEL_W    = 3;
  localparam int NUM_LEVELS = 7;
  localparam logic [LEVEL_W-1:0] NMI_LEVEL = 3'd7;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    RSP_VEC,
    RSP_AUTO,
    RSP_BERR
  } resp_t;

endpackage

// File: rtl/interrupt_encoder.sv
// Combinational active-low priority encoder: highest asserted a_n bit wins.
module interrupt_encoder
  import interrupt_pkg::*;
(
  input  logic [NUM_LEVELS-1:0] a_n,
  output logic [LEVEL_W-1:0]    y_n
);

  always_comb begin
    y_n = '1;
    // Ascending scan so the highest active level overwrites lower ones.
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (!a_n[i]) y_n = ~LEVEL_W'(i + 1);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Synchronises IRQ lines, latches edge requests, drives IPL and answers
// the CPU interrupt-acknowledge cycle with a vector, autovector or bus error.
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter logic [7:0]            VECTOR_BASE     = 8'h40,
  parameter logic [NUM_LEVELS-1:0] EDGE_MASK       = 7'b1000000,
  parameter logic [NUM_LEVELS-1:0] AUTOVECTOR_MASK = 7'b0000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_LEVELS-1:0] irq_n,
  input  logic                  iack,
  input  logic [LEVEL_W-1:0]    iack_level,
  output logic [LEVEL_W-1:0]    ipl_n,
  output logic [7:0]            vector,
  output logic                  vector_valid,
  output logic                  vpa_n,
  output logic                  berr_n
);

  // NMI is always edge-triggered regardless of the configured mask.
  localparam logic [NUM_LEVELS-1:0] EDGE_EFF =
    EDGE_MASK | (NUM_LEVELS'(1) << (NMI_LEVEL - 3'd1));
  localparam logic [NUM_LEVELS:0] AUTO8 = {AUTOVECTOR_MASK, 1'b0};

  logic [NUM_LEVELS-1:0] sync1, sync2, sync_d;
  logic [NUM_LEVELS-1:0] fall, pend_q, pend_vec, clr;
  logic [NUM_LEVELS:0]   pend8;
  logic [LEVEL_W-1:0]    prio_n;
  logic [LEVEL_W-1:0]    level_q;
  resp_t                 kind_q, take_kind;
  state_t                state, state_nxt;
  logic                  take;

  // Synchroniser and previous-sample register for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '1;
      sync2  <= '1;
      sync_d <= '1;
    end else begin
      sync1  <= irq_n;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  // A fresh edge counts as pending in the same cycle so edge and level
  // lines share the same irq_n-to-ipl_n latency.
  assign fall     = sync_d & ~sync2;
  assign pend_vec = (EDGE_EFF & (pend_q | fall)) | (~EDGE_EFF & ~sync2);
  assign pend8    = {pend_vec, 1'b0};
  assign take     = (state == IDLE) && iack;

  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      clr[i] = take && (iack_level == LEVEL_W'(i + 1)) && EDGE_EFF[i];
    end
  end

  // Set has priority over the acknowledge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= ((pend_q & ~clr) | fall) & EDGE_EFF;
    end
  end

  interrupt_encoder u_encoder (
    .a_n (~pend_vec),
    .y_n (prio_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ipl_n <= '1;
    end else begin
      ipl_n <= prio_n;
    end
  end

  // Response classification, captured once on entry to RESP
  always_comb begin
    take_kind = RSP_BERR;
    if (pend8[iack_level]) begin
      take_kind = AUTO8[iack_level] ? RSP_AUTO : RSP_VEC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q <= RSP_BERR;
    end else if (take) begin
      kind_q <= take_kind;
    end
  end

  always_ff @(posedge clk) begin
    if (take) level_q <= iack_level;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (iack)  state_nxt = RESP;
      RESP: if (!iack) state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from registered state only, so they are stable in RESP.
  always_comb begin
    vector       = 8'h00;
    vector_valid = 1'b0;
    vpa_n        = 1'b1;
    berr_n       = 1'b1;
    if (state == RESP) begin
      case (kind_q)
        RSP_VEC: begin
          vector       = VECTOR_BASE + {5'd0, level_q};
          vector_valid = 1'b1;
        end
        RSP_AUTO: vpa_n  = 1'b0;
        default:  berr_n = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scoreboard bench for interrupt_controller.
module tb_interrupt_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] irq_n;
  logic       iack;
  logic [2:0] iack_level;
  logic [2:0] ipl_n;
  logic [7:0] vector;
  logic       vector_valid;
  logic       vpa_n;
  logic       berr_n;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] ipl;
    logic [7:0] vec;
    logic       vv;
    logic       vpa;
    logic       berr;
  } exp_t;

  exp_t sb[$];

  interrupt_controller #(
    .VECTOR_BASE     (8'h40),
    .EDGE_MASK       (7'b1000000),
    .AUTOVECTOR_MASK (7'b0000010)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_n        (irq_n),
    .iack         (iack),
    .iack_level   (iack_level),
    .ipl_n        (ipl_n),
    .vector       (vector),
    .vector_valid (vector_valid),
    .vpa_n        (vpa_n),
    .berr_n       (berr_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] ipl, input logic [7:0] vec,
                          input logic vv, input logic vpa, input logic berr);
    exp_t e;
    e.ipl = ipl; e.vec = vec; e.vv = vv; e.vpa = vpa; e.berr = berr;
    sb.push_back(e);
  endtask

  task automatic push_idle(input logic [2:0] ipl);
    push_exp(ipl, 8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    int   active;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard empty observed 0 expected 1", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (ipl_n === e.ipl) else begin
        errors++;
        $error("FAIL %s.ipl_n observed %b expected %b", tag, ipl_n, e.ipl);
      end
      checks++;
      assert (vector === e.vec) else begin
        errors++;
        $error("FAIL %s.vector observed %h expected %h", tag, vector, e.vec);
      end
      checks++;
      assert (vector_valid === e.vv) else begin
        errors++;
        $error("FAIL %s.vector_valid observed %b expected %b", tag, vector_valid, e.vv);
      end
      checks++;
      assert (vpa_n === e.vpa) else begin
        errors++;
        $error("FAIL %s.vpa_n observed %b expected %b", tag, vpa_n, e.vpa);
      end
      checks++;
      assert (berr_n === e.berr) else begin
        errors++;
        $error("FAIL %s.berr_n observed %b expected %b", tag, berr_n, e.berr);
      end
    end
    active = int'(vector_valid) + int'(!vpa_n) + int'(!berr_n);
    checks++;
    assert (active <= 1) else begin
      errors++;
      $error("FAIL %s.exclusive observed %0d expected <=1", tag, active);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    irq_n      = 7'h7F;
    iack       = 1'b0;
    iack_level = 3'd0;

    // Reset and idle
    push_idle(3'b111);
    step(2);
    check_out("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_idle(3'b111);
      step(1);
      check_out("idle");
    end

    // Levels 3, 5 and 7 together: three-edge latency to IPL 0
    irq_n = 7'b0101011;
    push_idle(3'b111);
    step(2);
    check_out("lat2");
    push_idle(3'b000);
    step(1);
    check_out("lat3");
    // NMI released but still latched
    irq_n = 7'b1101011;
    push_idle(3'b000);
    step(4);
    check_out("nmi_held");

    // Acknowledge NMI: vector 0x47, pend clears, IPL falls back to level 5
    iack = 1'b1; iack_level = 3'd7;
    push_exp(3'b000, 8'h47, 1'b1, 1'b1, 1'b1);
    step(1);
    check_out("nmi_vec");
    push_exp(3'b010, 8'h47, 1'b1, 1'b1, 1'b1);
    step(1);
    check_out("nmi_hold");
    iack = 1'b0;
    push_idle(3'b010);
    step(1);
    check_out("nmi_drop");

    // Level 3 only, level-sensitive acknowledge, then back-to-back spurious
    irq_n = 7'b1111011;
    push_idle(3'b100);
    step(3);
    check_out("lvl3_ipl");
    iack = 1'b1; iack_level = 3'd3;
    push_exp(3'b100, 8'h43, 1'b1, 1'b1, 1'b1);
    step(1);
    check_out("lvl3_vec");
    iack = 1'b0;
    push_idle(3'b100);
    step(1);
    check_out("b2b_gap");
    iack = 1'b1; iack_level = 3'd4;
    push_exp(3'b100, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1);
    check_out("b2b_berr");
    iack = 1'b0;
    push_idle(3'b100);
    step(1);
    check_out("b2b_drop");

    // Autovector on level 2
    irq_n = 7'b1111101;
    push_idle(3'b101);
    step(3);
    check_out("auto_ipl");
    iack = 1'b1; iack_level = 3'd2;
    push_exp(3'b101, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1);
    check_out("auto_vpa");
    push_exp(3'b101, 8'h00, 1'b0, 1'b0, 1'b1);
    step(2);
    check_out("auto_hold");
    iack = 1'b0;
    push_idle(3'b101);
    step(1);
    check_out("auto_drop");

    // Spurious with no requests, levels 4 and 0
    irq_n = 7'h7F;
    push_idle(3'b111);
    step(3);
    check_out("spur_idle");
    iack = 1'b1; iack_level = 3'd4;
    push_exp(3'b111, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1);
    check_out("spur4");
    iack = 1'b0;
    push_idle(3'b111);
    step(1);
    check_out("spur4_drop");
    iack = 1'b1; iack_level = 3'd0;
    push_exp(3'b111, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1);
    check_out("spur0");
    iack = 1'b0;
    push_idle(3'b111);
    step(1);
    check_out("spur0_drop");

    // Short NMI pulse stays latched
    irq_n = 7'b0111111;
    step(2);
    irq_n = 7'h7F;
    push_idle(3'b000);
    step(1);
    check_out("pulse_ipl");
    push_idle(3'b000);
    step(3);
    check_out("pulse_held");

    // New NMI edge lands on the RESP-entry cycle: set beats clear
    irq_n = 7'b0111111;
    step(2);
    iack = 1'b1; iack_level = 3'd7;
    push_exp(3'b000, 8'h47, 1'b1, 1'b1, 1'b1);
    step(1);
    check_out("coll_vec");
    iack = 1'b0;
    push_idle(3'b000);
    step(1);
    check_out("coll_pend");
    push_idle(3'b000);
    step(2);
    check_out("coll_keep");
    iack = 1'b1;
    push_exp(3'b000, 8'h47, 1'b1, 1'b1, 1'b1);
    step(1);
    check_out("coll_ack2");
    iack = 1'b0;
    push_idle(3'b111);
    step(1);
    check_out("coll_clear");

    // Asynchronous reset in the middle of a response
    irq_n = 7'b1111011;
    step(3);
    iack = 1'b1; iack_level = 3'd3;
    push_exp(3'b100, 8'h43, 1'b1, 1'b1, 1'b1);
    step(1);
    check_out("mid_vec");
    #2;
    rst_n = 1'b0;
    push_idle(3'b111);
    #1;
    check_out("mid_reset");
    iack  = 1'b0;
    irq_n = 7'h7F;
    step(1);
    rst_n = 1'b1;
    push_idle(3'b111);
    step(2);
    check_out("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
